// File: rtl/digital_clock_pkg.sv
// digital_clock_pkg: shared mode encodings, BCD limits and the integer-to-BCD helper
package digital_clock_pkg;
  localparam logic [1:0] MODE_RUN = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;
  localparam logic [1:0] MODE_SET_SEC = 2'd3;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_11 = 8'h11;
  typedef enum logic [1:0] {
    ST_RUN = MODE_RUN,
    ST_SET_HOUR = MODE_SET_HOUR,
    ST_SET_MIN = MODE_SET_MIN,
    ST_SET_SEC = MODE_SET_SEC
  } mode_t;
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/time_counter_if.sv
// time_counter_if: seconds input, buttons and BCD time/status outputs; slave = counter, master = driver
interface time_counter_if;
  logic sec_clk_i;
  logic mode_btn;
  logic inc_btn;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] mode_o;
  logic sec_tick;
  logic day_wrap;
  modport master(output sec_clk_i, mode_btn, inc_btn,
                 input hour_bcd, min_bcd, sec_bcd, mode_o, sec_tick, day_wrap);
  modport slave(input sec_clk_i, mode_btn, inc_btn,
                output hour_bcd, min_bcd, sec_bcd, mode_o, sec_tick, day_wrap);
endinterface

// File: rtl/time_counter_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MOD-1 (ports: clk, rst, inc, value, carry)
module bcd_mod_counter
  import digital_clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);
  localparam logic [7:0] MAX = to_bcd(MOD - 1);
  logic [7:0] nxt;
  always_comb
    nxt = value == MAX ? 8'h00 :
          value[3:0] == 4'd9 ? {value[7:4] + 4'd1, 4'd0} : {value[7:4], value[3:0] + 4'd1};
  assign carry = inc && value == MAX;
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (inc) value <= nxt;
endmodule

// File: rtl/time_counter.sv
// time_counter: BCD time of day driven by a 1 Hz edge, with RUN/SET mode FSM (ports: clk, rst, bus slave)
module time_counter
  import digital_clock_pkg::*;
#(
  parameter int HOUR_MOD = 24,
  parameter int MIN_MOD = 60
) (
  input logic clk,
  input logic rst,
  time_counter_if.slave bus
);
  mode_t state, state_n;
  logic sec_clk_d, tick, run, set_inc;
  logic sec_inc, min_inc, hour_inc;
  logic sec_carry, min_carry, hour_carry;
  logic sec_tick_r, day_wrap_r;
  assign tick = bus.sec_clk_i & ~sec_clk_d;
  assign run = state == ST_RUN;
  // a mode press in the same cycle swallows the increment
  assign set_inc = bus.inc_btn & ~bus.mode_btn;
  always_comb state_n = bus.mode_btn ? mode_t'(state + 2'd1) : state;
  // RUN chains carries from the tick; SET modes feed the button to one field with no carry
  assign sec_inc = run ? tick : set_inc && state == ST_SET_SEC;
  assign min_inc = run ? sec_carry : set_inc && state == ST_SET_MIN;
  assign hour_inc = run ? min_carry : set_inc && state == ST_SET_HOUR;
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_RUN;
      sec_clk_d <= 1'b0;
      sec_tick_r <= 1'b0;
      day_wrap_r <= 1'b0;
    end else begin
      state <= state_n;
      sec_clk_d <= bus.sec_clk_i;
      sec_tick_r <= tick;
      day_wrap_r <= run & hour_carry;
    end
  bcd_mod_counter #(.MOD(MIN_MOD)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .value(bus.sec_bcd), .carry(sec_carry)
  );
  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .value(bus.min_bcd), .carry(min_carry)
  );
  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk(clk), .rst(rst), .inc(hour_inc), .value(bus.hour_bcd), .carry(hour_carry)
  );
  assign bus.mode_o = state;
  assign bus.sec_tick = sec_tick_r;
  assign bus.day_wrap = day_wrap_r;
endmodule
